// File: rtl/memory_access.sv
// Purpose: MEM pipeline stage. Issues data-bus requests for loads/stores,
//   stalls upstream while a bus access is outstanding, times out after
//   WAIT_MAX unacknowledged WAIT cycles, sizes load data and holds the MEM/WB
//   pipeline register.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   *_mem_i               MEM-stage instruction fields
//   stall_mem_o           holds all upstream stages (combinational)
//   dmem_*                data bus request / response
//   *_wb_o                MEM/WB register outputs
//   bus_err_o             one-cycle bus timeout pulse (registered)
//   misaligned_o          one-cycle misaligned-access pulse (registered)
// Configuration: define MEM_MISALIGN_CHECK_EN to trap misaligned H/W accesses;
//   when undefined, misaligned_o is tied 0 and low address bits are ignored.
module memory_access #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_mem_i,
  input  logic        mem_read_mem_i,
  input  logic        mem_write_mem_i,
  input  logic [2:0]  funct3_mem_i,
  input  logic [31:0] alu_result_mem_i,
  input  logic [31:0] write_data_mem_i,
  input  logic [31:0] pc_next_4_mem_i,
  input  logic [31:0] pc_next_imm_mem_i,
  input  logic [1:0]  result_src_mem_i,
  input  logic        reg_write_mem_i,
  input  logic [4:0]  rd_mem_i,
  output logic        stall_mem_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_wb_o,
  output logic        reg_write_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [1:0]  result_src_wb_o,
  output logic [31:0] alu_result_wb_o,
  output logic [31:0] read_data_sized_wb_o,
  output logic [31:0] pc_next_4_wb_o,
  output logic [31:0] pc_next_imm_wb_o,
  output logic        bus_err_o,
  output logic        misaligned_o
);

  localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access_c, mis_c, req_c, timeout_c, stall_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] sized_c;

  logic        valid_d, rw_d, berr_d, mis_d;
  logic [4:0]  rd_d;
  logic [1:0]  rsrc_d;
  logic [31:0] alu_d, rdata_d, pc4_d, pcimm_d;
  logic        valid_q, rw_q, berr_q, mis_q;
  logic [4:0]  rd_q;
  logic [1:0]  rsrc_q;
  logic [31:0] alu_q, rdata_q, pc4_q, pcimm_q;

  // Access qualification, optional alignment trap, request and stall.
  always_comb begin
    access_c = valid_mem_i & (mem_read_mem_i | mem_write_mem_i);
`ifdef MEM_MISALIGN_CHECK_EN
    mis_c = access_c &
            (((funct3_mem_i[1:0] == 2'b01) & alu_result_mem_i[0]) |
             ((funct3_mem_i[1:0] == 2'b10) & (alu_result_mem_i[1:0] != 2'b00)));
`else
    mis_c = 1'b0;
`endif
    req_c     = access_c & ~mis_c & ~rst_i;
    // Ack on the last permitted WAIT cycle still completes the access.
    timeout_c = (state_q == S_WAIT) & req_c & ~dmem_ack_i &
                (cnt_q == CNT_W'(WAIT_MAX - 1));
    stall_c   = req_c & ~dmem_ack_i & ~timeout_c;
  end

  // Store byte-lane steering.
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = write_data_mem_i;
    case (funct3_mem_i[1:0])
      2'b00: begin
        dmem_be_o    = 4'b0001 << alu_result_mem_i[1:0];
        dmem_wdata_o = {4{write_data_mem_i[7:0]}};
      end
      2'b01: begin
        dmem_be_o    = 4'b0011 << {alu_result_mem_i[1], 1'b0};
        dmem_wdata_o = {2{write_data_mem_i[15:0]}};
      end
      2'b10:   dmem_be_o = 4'b1111;
      default: dmem_be_o = 4'b0000;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    case (alu_result_mem_i[1:0])
      2'b00:   byte_c = dmem_rdata_i[7:0];
      2'b01:   byte_c = dmem_rdata_i[15:8];
      2'b10:   byte_c = dmem_rdata_i[23:16];
      default: byte_c = dmem_rdata_i[31:24];
    endcase
    half_c = alu_result_mem_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_mem_i)
      3'b000:  sized_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  sized_c = {24'h000000, byte_c};
      3'b001:  sized_c = {{16{half_c[15]}}, half_c};
      3'b101:  sized_c = {16'h0000, half_c};
      3'b010:  sized_c = dmem_rdata_i;
      default: sized_c = 32'h0000_0000;
    endcase
  end

  // Next-state: FSM, wait counter and MEM/WB register (bubble while stalled).
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    valid_d = 1'b0;
    rw_d    = 1'b0;
    berr_d  = 1'b0;
    mis_d   = 1'b0;
    rd_d    = '0;
    rsrc_d  = '0;
    alu_d   = '0;
    rdata_d = '0;
    pc4_d   = '0;
    pcimm_d = '0;
    if (stall_c) begin
      state_d = S_WAIT;
      cnt_d   = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      valid_d = valid_mem_i;
      rw_d    = reg_write_mem_i & valid_mem_i & ~timeout_c & ~mis_c;
      berr_d  = timeout_c;
      mis_d   = mis_c;
      rd_d    = rd_mem_i;
      rsrc_d  = result_src_mem_i;
      alu_d   = alu_result_mem_i;
      pc4_d   = pc_next_4_mem_i;
      pcimm_d = pc_next_imm_mem_i;
      rdata_d = (req_c & mem_read_mem_i & dmem_ack_i) ? sized_c : 32'h0000_0000;
    end
  end

  // State and MEM/WB register update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      rsrc_q  <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      pcimm_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      berr_q  <= berr_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      rsrc_q  <= rsrc_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
      pcimm_q <= pcimm_d;
    end
  end

  assign stall_mem_o          = stall_c;
  assign dmem_req_o           = req_c;
  assign dmem_we_o            = mem_write_mem_i;
  assign dmem_addr_o          = {alu_result_mem_i[31:2], 2'b00};
  assign valid_wb_o           = valid_q;
  assign reg_write_wb_o       = rw_q;
  assign rd_wb_o              = rd_q;
  assign result_src_wb_o      = rsrc_q;
  assign alu_result_wb_o      = alu_q;
  assign read_data_sized_wb_o = rdata_q;
  assign pc_next_4_wb_o       = pc4_q;
  assign pc_next_imm_wb_o     = pcimm_q;
  assign bus_err_o            = berr_q;
  assign misaligned_o         = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: behavioural model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_memory_access;

  localparam int unsigned WM = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_mem_i, mem_read_mem_i, mem_write_mem_i, reg_write_mem_i;
  logic [2:0]  funct3_mem_i;
  logic [31:0] alu_result_mem_i, write_data_mem_i, pc_next_4_mem_i, pc_next_imm_mem_i;
  logic [1:0]  result_src_mem_i;
  logic [4:0]  rd_mem_i;
  logic        stall_mem_o, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        valid_wb_o, reg_write_wb_o, bus_err_o, misaligned_o;
  logic [4:0]  rd_wb_o;
  logic [1:0]  result_src_wb_o;
  logic [31:0] alu_result_wb_o, read_data_sized_wb_o, pc_next_4_wb_o, pc_next_imm_wb_o;

  int n_checks = 0;
  int n_pass   = 0;

  memory_access #(.WAIT_MAX(WM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_mem_i(valid_mem_i), .mem_read_mem_i(mem_read_mem_i),
    .mem_write_mem_i(mem_write_mem_i), .funct3_mem_i(funct3_mem_i),
    .alu_result_mem_i(alu_result_mem_i), .write_data_mem_i(write_data_mem_i),
    .pc_next_4_mem_i(pc_next_4_mem_i), .pc_next_imm_mem_i(pc_next_imm_mem_i),
    .result_src_mem_i(result_src_mem_i), .reg_write_mem_i(reg_write_mem_i),
    .rd_mem_i(rd_mem_i), .stall_mem_o(stall_mem_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_wb_o(valid_wb_o), .reg_write_wb_o(reg_write_wb_o), .rd_wb_o(rd_wb_o),
    .result_src_wb_o(result_src_wb_o), .alu_result_wb_o(alu_result_wb_o),
    .read_data_sized_wb_o(read_data_sized_wb_o), .pc_next_4_wb_o(pc_next_4_wb_o),
    .pc_next_imm_wb_o(pc_next_imm_wb_o), .bus_err_o(bus_err_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Load result from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * a[1:0])) & 32'hFF;
    h = (data >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      3'b010:  return data;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_wait = 0;       // cycles the current access has already stalled
  bit          have_exp = 0;
  bit          e_bubble, e_valid, e_rw, e_berr, e_mis;
  logic [4:0]  e_rd;
  logic [1:0]  e_rsrc;
  logic [31:0] e_alu, e_rdata, e_pc4, e_pcimm;

  always @(negedge clk_i) begin
    bit acc, mis, req, tmo, stl;
    logic [31:0] a, exp_be, exp_wd;
    a   = alu_result_mem_i;
    acc = valid_mem_i && (mem_read_mem_i || mem_write_mem_i);
    mis = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    if (acc && funct3_mem_i[1:0] == 2'b01 && (a % 2) != 0) mis = 1;
    if (acc && funct3_mem_i[1:0] == 2'b10 && (a % 4) != 0) mis = 1;
`endif
    req = acc && !mis && !rst_i;
    tmo = req && !dmem_ack_i && (m_wait == WM);
    stl = req && !dmem_ack_i && !tmo;

    if (have_exp) begin
      check("wb_valid", 32'(valid_wb_o), 32'(e_valid));
      check("wb_reg_write", 32'(reg_write_wb_o), 32'(e_rw));
      check("wb_bus_err", 32'(bus_err_o), 32'(e_berr));
      check("wb_misaligned", 32'(misaligned_o), 32'(e_mis));
      if (!e_bubble) begin
        check("wb_rd", 32'(rd_wb_o), 32'(e_rd));
        check("wb_result_src", 32'(result_src_wb_o), 32'(e_rsrc));
        check("wb_alu", alu_result_wb_o, e_alu);
        check("wb_read_data", read_data_sized_wb_o, e_rdata);
        check("wb_pc4", pc_next_4_wb_o, e_pc4);
        check("wb_pcimm", pc_next_imm_wb_o, e_pcimm);
      end
    end

    check("stall", 32'(stall_mem_o), 32'(stl));
    if (!tmo) check("req", 32'(dmem_req_o), 32'(req));
    if (req) begin
      check("addr", dmem_addr_o, a - (a % 4));
      check("we", 32'(dmem_we_o), 32'(mem_write_mem_i));
      if (mem_write_mem_i) begin
        case (funct3_mem_i[1:0])
          2'b00: begin exp_be = 32'(1) << (a % 4); exp_wd = (write_data_mem_i & 32'hFF) * 32'h0101_0101; end
          2'b01: begin exp_be = 32'(3) << (a & 2); exp_wd = (write_data_mem_i & 32'hFFFF) * 32'h0001_0001; end
          default: begin exp_be = 32'hF; exp_wd = write_data_mem_i; end
        endcase
        check("be", 32'(dmem_be_o), exp_be);
        check("wdata", dmem_wdata_o, exp_wd);
      end
    end

    // Expected MEM/WB contents after the coming edge.
    e_bubble = 0; e_valid = 0; e_rw = 0; e_berr = 0; e_mis = 0;
    e_rd = 0; e_rsrc = 0; e_alu = 0; e_rdata = 0; e_pc4 = 0; e_pcimm = 0;
    if (rst_i) begin
      m_wait = 0;
    end else if (stl) begin
      e_bubble = 1;
      m_wait++;
    end else begin
      e_valid = valid_mem_i;
      e_rw    = reg_write_mem_i && valid_mem_i && !tmo && !mis;
      e_berr  = tmo;
      e_mis   = mis;
      e_rd    = rd_mem_i;
      e_rsrc  = result_src_mem_i;
      e_alu   = a;
      e_pc4   = pc_next_4_mem_i;
      e_pcimm = pc_next_imm_mem_i;
      e_rdata = (req && mem_read_mem_i && dmem_ack_i) ? load_value(funct3_mem_i, a, dmem_rdata_i) : 32'h0;
      m_wait  = 0;
    end
    have_exp = 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    valid_mem_i = 0; mem_read_mem_i = 0; mem_write_mem_i = 0; reg_write_mem_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 32'h0;
  endtask

  // Present one instruction, ack on cycle index ack_at (-1 = never), run to completion.
  task automatic run_op(input logic [2:0] f3, input bit rd, input bit wr, input bit rw,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ack_at, output int stalls, output logic [3:0] be0,
                        output logic [31:0] wd0, output bit req0);
    int  k;
    bit  done, st;
    valid_mem_i = 1; mem_read_mem_i = rd; mem_write_mem_i = wr; reg_write_mem_i = rw;
    funct3_mem_i = f3; alu_result_mem_i = addr; write_data_mem_i = wd;
    pc_next_4_mem_i = addr + 32'h1000; pc_next_imm_mem_i = addr + 32'h2000;
    rd_mem_i = addr[4:0] ^ 5'd9; result_src_mem_i = {rd, wr};
    stalls = 0; k = 0; done = 0; be0 = 0; wd0 = 0; req0 = 0;
    while (!done) begin
      dmem_ack_i   = (k == ack_at);
      dmem_rdata_i = (k == ack_at) ? rdata : 32'h5A5A_5A5A;
      #3;
      if (k == 0) begin be0 = dmem_be_o; wd0 = dmem_wdata_o; req0 = dmem_req_o; end
      st = stall_mem_o;
      @(posedge clk_i); #1;
      if (st) stalls++; else done = 1;
      k++;
      if (!done && k > int'(WM) + 4) begin
        n_checks++;
        $display("FAIL op_timeout: stall still high after %0d cycles, expected release", k);
        done = 1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    int st; logic [3:0] be; logic [31:0] wd; bit rq;
    idle_inputs();
    funct3_mem_i = 3'b010; alu_result_mem_i = 0; write_data_mem_i = 0;
    pc_next_4_mem_i = 0; pc_next_imm_mem_i = 0; result_src_mem_i = 0; rd_mem_i = 0;
    rst_i = 1;
    valid_mem_i = 1; mem_read_mem_i = 1; reg_write_mem_i = 1;  // access held in reset
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", 32'(dmem_req_o), 32'h0);
    check("rst_stall", 32'(stall_mem_o), 32'h0);
    check("rst_valid_wb", 32'(valid_wb_o), 32'h0);
    check("rst_read_data", read_data_sized_wb_o, 32'h0);
    idle_inputs();
    rst_i = 0;
    @(posedge clk_i); #1;

    // LW 0x100, ack on fourth cycle
    run_op(3'b010, 1, 0, 1, 32'h100, 0, 32'hDEADBEEF, 3, st, be, wd, rq);
    check("lw_stalls", 32'(st), 32'd3);
    check("lw_data", read_data_sized_wb_o, 32'hDEADBEEF);
    check("lw_reg_write", 32'(reg_write_wb_o), 32'h1);

    // LB / LBU 0x103, same-cycle ack
    run_op(3'b000, 1, 0, 1, 32'h103, 0, 32'h80FF_FFFF, 0, st, be, wd, rq);
    check("lb_stalls", 32'(st), 32'd0);
    check("lb_data", read_data_sized_wb_o, 32'hFFFF_FF80);
    run_op(3'b100, 1, 0, 1, 32'h103, 0, 32'h80FF_FFFF, 0, st, be, wd, rq);
    check("lbu_data", read_data_sized_wb_o, 32'h0000_0080);

    // LH / LHU upper half
    run_op(3'b001, 1, 0, 1, 32'h202, 0, 32'h9876_0011, 1, st, be, wd, rq);
    check("lh_data", read_data_sized_wb_o, 32'hFFFF_9876);
    run_op(3'b101, 1, 0, 1, 32'h202, 0, 32'h9876_0011, 0, st, be, wd, rq);
    check("lhu_data", read_data_sized_wb_o, 32'h0000_9876);

    // SH 0x102
    run_op(3'b001, 0, 1, 0, 32'h102, 32'h1234_ABCD, 0, 2, st, be, wd, rq);
    check("sh_be", 32'(be), 32'hC);
    check("sh_wdata", wd, 32'hABCD_ABCD);
    check("sh_reg_write", 32'(reg_write_wb_o), 32'h0);
    check("sh_read_data", read_data_sized_wb_o, 32'h0);

    // SB 0x101, SW 0x10C
    run_op(3'b000, 0, 1, 0, 32'h101, 32'h0000_00A5, 0, 0, st, be, wd, rq);
    check("sb_be", 32'(be), 32'h2);
    check("sb_wdata", wd, 32'hA5A5_A5A5);
    run_op(3'b010, 0, 1, 0, 32'h10C, 32'hCAFE_F00D, 0, 1, st, be, wd, rq);
    check("sw_be", 32'(be), 32'hF);

    // Non-memory ALU op passes straight through
    run_op(3'b000, 0, 0, 1, 32'h0000_0777, 0, 0, -1, st, be, wd, rq);
    check("alu_stalls", 32'(st), 32'd0);
    check("alu_reg_write", 32'(reg_write_wb_o), 32'h1);
    check("alu_result", alu_result_wb_o, 32'h0000_0777);

    // Timeout: never acked
    run_op(3'b010, 1, 0, 1, 32'h300, 0, 0, -1, st, be, wd, rq);
    check("tmo_stalls", 32'(st), 32'(WM));
    check("tmo_bus_err", 32'(bus_err_o), 32'h1);
    check("tmo_reg_write", 32'(reg_write_wb_o), 32'h0);
    @(posedge clk_i); #1;
    check("tmo_pulse_end", 32'(bus_err_o), 32'h0);
    check("tmo_req_idle", 32'(dmem_req_o), 32'h0);

    // Ack on the final permitted cycle beats the timeout
    run_op(3'b010, 1, 0, 1, 32'h304, 0, 32'h1357_9BDF, int'(WM), st, be, wd, rq);
    check("ackwin_bus_err", 32'(bus_err_o), 32'h0);
    check("ackwin_data", read_data_sized_wb_o, 32'h1357_9BDF);
    check("ackwin_reg_write", 32'(reg_write_wb_o), 32'h1);

    // Reset during WAIT, then a late ack
    valid_mem_i = 1; mem_read_mem_i = 1; reg_write_mem_i = 1;
    funct3_mem_i = 3'b010; alu_result_mem_i = 32'h400;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1;
    #3;
    check("rstw_req", 32'(dmem_req_o), 32'h0);
    check("rstw_stall", 32'(stall_mem_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 0;
    idle_inputs();
    dmem_ack_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
    #3;
    check("late_ack_req", 32'(dmem_req_o), 32'h0);
    @(posedge clk_i); #1;
    dmem_ack_i = 0;
    check("late_ack_reg_write", 32'(reg_write_wb_o), 32'h0);
    check("late_ack_data", read_data_sized_wb_o, 32'h0);

    // LW at misaligned 0x101
`ifdef MEM_MISALIGN_CHECK_EN
    run_op(3'b010, 1, 0, 1, 32'h101, 0, 0, -1, st, be, wd, rq);
    check("mis_req", 32'(rq), 32'h0);
    check("mis_pulse", 32'(misaligned_o), 32'h1);
    check("mis_reg_write", 32'(reg_write_wb_o), 32'h0);
    @(posedge clk_i); #1;
    check("mis_pulse_end", 32'(misaligned_o), 32'h0);
`else
    alu_result_mem_i = 32'h101;
    run_op(3'b010, 1, 0, 1, 32'h101, 0, 32'h2468_ACE0, 0, st, be, wd, rq);
    check("mis_req", 32'(rq), 32'h1);
    check("mis_be", 32'(be), 32'hF);
    check("mis_misaligned", 32'(misaligned_o), 32'h0);
    check("mis_data", read_data_sized_wb_o, 32'h2468_ACE0);
`endif

    repeat (2) @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
